// File: rtl/systolic_feeder.sv
// systolic_feeder: holds two 4x4 signed operand matrices (A, B) and, on start,
// streams them skewed into the west and north edges of a 4x4 systolic array.
// The sequence is: clear the PE accumulators, feed for 7 steps, idle for
// FLUSH_CYC cycles, then hold the drain enable for DRAIN_CYC cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en/wr_sel      operand write strobe; sel 0 = A, 1 = B
//   wr_addr/wr_data   {row, col} and value of the write (ignored while busy)
//   start             begin a pass (accepted only in IDLE)
//   west_data/vld[r]  A row r stream, lane r skewed by r cycles
//   north_data/vld[c] B column c stream, lane c skewed by c cycles
//   acc_clr           one cycle, at the start of every pass
//   out_phase         drain enable
//   busy, done        pass in progress / one-cycle end-of-pass pulse
//
// Handshake: there is no back-pressure. start is a level sampled on each
// rising edge while IDLE; a sampled start always produces a full pass.
// All outputs are registers loaded from the next-state decode, so every
// output lines up with the state it describes. DRAIN_CYC is assumed >= 1.
module systolic_feeder #(
  parameter int BW        = 16,
  parameter int FLUSH_CYC = 4,
  parameter int DRAIN_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [3:0]           wr_addr,
  input  logic signed [BW-1:0] wr_data,
  input  logic                 start,
  output logic signed [BW-1:0] west_data [4],
  output logic [3:0]           west_vld,
  output logic signed [BW-1:0] north_data [4],
  output logic [3:0]           north_vld,
  output logic                 acc_clr,
  output logic                 out_phase,
  output logic                 busy,
  output logic                 done
);

  localparam int CMAX = (FLUSH_CYC > DRAIN_CYC) ?
                        ((FLUSH_CYC > 7) ? FLUSH_CYC : 7) :
                        ((DRAIN_CYC > 7) ? DRAIN_CYC : 7);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(6);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, CLR, FEED, FLUSH, DRAIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_n;

  logic signed [BW-1:0] a_mem [4][4];
  logic signed [BW-1:0] b_mem [4][4];

  logic signed [BW-1:0] west_data_n  [4];
  logic signed [BW-1:0] north_data_n [4];
  logic [3:0]           west_vld_n, north_vld_n;

  // Operand storage: no reset, so matrices survive reset and passes.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      if (!wr_sel) a_mem[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
      else         b_mem[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt counts cycles within the current state and restarts at every change.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    done_n  = 1'b0;
    case (state)
      IDLE:  if (start) state_n = CLR;
      CLR:   state_n = FEED;
      FEED: begin
        if (cnt == FEED_LAST) state_n = (FLUSH_CYC == 0) ? DRAIN : FLUSH;
        else                  cnt_n   = cnt + 1'b1;
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) state_n = DRAIN;
        else                   cnt_n   = cnt + 1'b1;
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lane skew: lane i carries element (t - i) during steps i..i+3. d is the
  // 4-bit difference t - i; d[3:2] == 0 exactly when 0 <= t - i <= 3.
  always_comb begin
    logic [3:0] d;
    west_vld_n  = '0;
    north_vld_n = '0;
    d           = '0;
    for (int i = 0; i < 4; i++) begin
      west_data_n[i]  = '0;
      north_data_n[i] = '0;
      d = {1'b0, cnt_n[2:0]} - 4'(i);
      if (state_n == FEED && d[3:2] == 2'b00) begin
        west_vld_n[i]   = 1'b1;
        north_vld_n[i]  = 1'b1;
        west_data_n[i]  = a_mem[i][d[1:0]];
        north_data_n[i] = b_mem[d[1:0]][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      west_vld  <= '0;
      north_vld <= '0;
      acc_clr   <= 1'b0;
      out_phase <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        west_data[i]  <= '0;
        north_data[i] <= '0;
      end
    end else begin
      west_vld  <= west_vld_n;
      north_vld <= north_vld_n;
      acc_clr   <= (state_n == CLR);
      out_phase <= (state_n == DRAIN);
      busy      <= (state_n != IDLE);
      done      <= done_n;
      for (int i = 0; i < 4; i++) begin
        west_data[i]  <= west_data_n[i];
        north_data[i] <= north_data_n[i];
      end
    end
  end

endmodule
